pinmux_dio_in_filter: RTL
=========================

Name: pinmux_dio_in_filter

Overview:
- Sits directly downstream of the per-pad DIO pad attribute/wrapper instances, between the raw DIO pad inputs and the pinmux input matrix.
- Synchronises each DIO pad input into the core clock domain and optionally applies a stable-count glitch filter. Which pads are filterable is fixed by a parameter mask derived at top level from the target configuration's per-pad type: pads of type B are filterable.
- Produces filtered levels, rise/fall event pulses, and a saturating rejected-glitch counter for debug.

Parameters:
- NumPads, 24, number of DIO pads; equals NDioPads.
- FilterCycles, 4, consecutive mismatching synchronised samples required before a filtered pad output changes; legal range 2..255.
- PadIsFiltered, all ones (NumPads bits), per-pad mask; bit i set means pad i may be filtered, cleared means synchroniser only.
- GlitchCntW, 16, width of the rejected-glitch counter.

Ports:
- clk_i  input  1  core clock, only clock.
- rst_i  input  1  asynchronous, active-high reset.
- pad_in_i  input  NumPads  raw pad input levels, asynchronous to clk_i.
- filter_en_i  input  NumPads  runtime per-pad filter enable; only effective where PadIsFiltered is set.
- glitch_clr_i  input  1  synchronous clear of glitch_cnt_o.
- pad_filt_o  output  NumPads  filtered/synchronised pad levels (registered).
- rise_o  output  NumPads  one-cycle pulse when pad_filt_o bit goes 0->1.
- fall_o  output  NumPads  one-cycle pulse when pad_filt_o bit goes 1->0.
- glitch_cnt_o  output  GlitchCntW  saturating count of rejected glitches, all pads.

Behaviour:
- Reset: all synchroniser flops, pad_filt_o, rise_o, fall_o, per-pad counters and glitch_cnt_o are 0. Reset is asynchronous on assertion and releases on the clock.
- Synchroniser: two-flop sync per pad; sync2[i] is pad_in_i[i] delayed 2 edges.
- Effective mode per pad: filtered when PadIsFiltered[i] and filter_en_i[i] are both set; otherwise pass-through.
- Pass-through: pad_filt_o[i] <= sync2[i] on every edge; counter[i] is held at 0.
  - An input change captured at edge 0 appears on pad_filt_o at edge 3.
- Filtered mode, per pad counter of width clog2(FilterCycles), applied on each edge:
  - sync2 != pad_filt_o and counter == FilterCycles-1: pad_filt_o toggles, counter <= 0.
  - sync2 != pad_filt_o otherwise: counter increments.
  - sync2 == pad_filt_o and counter > 0: this is a rejected glitch; counter <= 0.
  - sync2 == pad_filt_o and counter == 0: no change.
  - A stable change captured at edge 0 appears on pad_filt_o at edge 2+FilterCycles.
- Mode change mid-count: when the effective mode drops to pass-through, counter clears immediately and is not counted as a glitch. When it rises to filtered, counting starts from 0.
- rise_o/fall_o:
  - Registered in the same edge as the pad_filt_o update, so each pulse is high exactly in the cycle the new pad_filt_o level is first visible.
  - Never both high for one pad.
- glitch_cnt_o:
  - On each edge, adds the number of pads that rejected a glitch in that cycle (0..NumPads); result saturates at all ones.
  - glitch_clr_i has priority: it sets the count to 0 and drops that cycle's increments.
  - Saturation holds until cleared.
- Pads are fully independent; simultaneous events on any subset of pads are legal.

Test Plan:
- Reset, all pads held 0 -> all outputs 0. Assert rst_i mid-count on pad 3 -> counter and outputs return to 0 asynchronously; no pulses after release.
- Pad 0 filtered, FilterCycles=4, pad_in_i[0] 0->1 held -> pad_filt_o[0]=1 at edge 6 after capture; rise_o[0] high exactly one cycle; glitch_cnt_o=0.
- Pad 0 filtered, 3-cycle high pulse -> pad_filt_o[0] stays 0; glitch_cnt_o=1. Repeat with 4-cycle pulse -> output rises, then falls; one rise and one fall pulse; count unchanged.
- Pad 5 with PadIsFiltered[5]=0, filter_en_i=all ones, 1-cycle pulse -> pad_filt_o[5] follows at 3-edge latency, rise then fall pulses; no glitch counted.
- 3-cycle glitch on pads 1, 2 and 7 in the same cycle -> glitch_cnt_o increments by exactly 3. Glitch coinciding with glitch_clr_i -> count 0.
- Preload near saturation (GlitchCntW=4, count 14) then 3 simultaneous glitches -> 15 and held; toggle filter_en_i[0] off mid-count -> no increment, pass-through resumes the next edge.

Source files
------------

// File: rtl/pinmux_dio_in_filter.sv
// pinmux_dio_in_filter: two-flop DIO pad synchroniser with optional per-pad stable-count
// glitch filter, edge pulses and a saturating rejected-glitch counter.
module pinmux_dio_in_filter #(
  parameter int NumPads = 24,
  parameter int FilterCycles = 4,
  parameter logic [NumPads-1:0] PadIsFiltered = '1,
  parameter int GlitchCntW = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumPads-1:0]    pad_in_i,
  input  logic [NumPads-1:0]    filter_en_i,
  input  logic                  glitch_clr_i,
  output logic [NumPads-1:0]    pad_filt_o,
  output logic [NumPads-1:0]    rise_o,
  output logic [NumPads-1:0]    fall_o,
  output logic [GlitchCntW-1:0] glitch_cnt_o
);
  localparam int CntW = $clog2(FilterCycles);
  localparam int SumW = $clog2(NumPads + 1);
  localparam int AccW = (GlitchCntW > SumW ? GlitchCntW : SumW) + 1;
  logic [NumPads-1:0] sync1, sync2, filt_d;
  logic [CntW-1:0] cnt_q [NumPads];
  logic [CntW-1:0] cnt_d [NumPads];
  logic [SumW-1:0] glitch_sum;
  logic [AccW-1:0] cnt_sum;
  always_comb begin
    glitch_sum = '0;
    for (int i = 0; i < NumPads; i++) begin
      filt_d[i] = pad_filt_o[i];
      cnt_d[i] = '0;
      if (!(PadIsFiltered[i] && filter_en_i[i])) filt_d[i] = sync2[i];
      else if (sync2[i] != pad_filt_o[i]) begin
        if (cnt_q[i] == CntW'(FilterCycles - 1)) filt_d[i] = sync2[i];
        else cnt_d[i] = cnt_q[i] + CntW'(1);
      end else if (cnt_q[i] != '0) glitch_sum = glitch_sum + SumW'(1);
    end
  end
  assign cnt_sum = AccW'(glitch_cnt_o) + AccW'(glitch_sum);
  // Any bit above the counter width means the add overflowed: saturate.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
      pad_filt_o <= '0;
      rise_o <= '0;
      fall_o <= '0;
      cnt_q <= '{default: '0};
      glitch_cnt_o <= '0;
    end else begin
      sync1 <= pad_in_i;
      sync2 <= sync1;
      pad_filt_o <= filt_d;
      rise_o <= filt_d & ~pad_filt_o;
      fall_o <= ~filt_d & pad_filt_o;
      cnt_q <= cnt_d;
      glitch_cnt_o <= glitch_clr_i ? '0 : (|cnt_sum[AccW-1:GlitchCntW]) ? '1 : cnt_sum[GlitchCntW-1:0];
    end
  end
endmodule
